neuron_mac_seq: RTL and testbench

Sequencer and multiply-accumulate engine for one neuron evaluation. It sits directly downstream of the weight memory. It drives the 16-bit weight address {layer, neuron, input index} and, in parallel, the activation address. It consumes the 8-bit signed weight and activation returned one cycle later, accumulates their products, then scales, clamps and optionally ReLUs the sum into an 8-bit signed neuron output with a one-cycle done pulse.

---
 rtl/neuron_mac_seq.sv | 80 ++++++++
 tb/tb_neuron_mac_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences weight/activation fetches for one neuron and
// accumulates, scales, clamps and optionally ReLUs the sum into an 8-bit output.
module neuron_mac_seq #(
    parameter int ACC_W = 26,
    parameter int SHIFT = 4,
    parameter int RELU  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  layer,
    input  logic [3:0]  neuron,
    input  logic [10:0] num_inputs,
    output logic [15:0] weight_addr,
    input  logic [7:0]  weight_val,
    output logic [9:0]  act_addr,
    input  logic [7:0]  act_val,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
    localparam logic signed [ACC_W-1:0] MAXV = 127;
    localparam logic signed [ACC_W-1:0] MINV = -128;
    state_t                   state;
    logic [10:0]              n;
    logic                     vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sh;
    logic signed [15:0]       prod;
    logic [10:0]              n_clamp;
    logic [7:0]               sat;
    always_comb begin
        n_clamp = num_inputs > 11'd1024 ? 11'd1024 : num_inputs;
        prod    = $signed(weight_val) * $signed(act_val);
        sh      = acc >>> SHIFT;
        sat     = (RELU != 0 && sh < 0) ? 8'd0 :
                  sh > MAXV ? 8'h7f :
                  sh < MINV ? 8'h80 : sh[7:0];
    end
    // The low address bits double as the fetch index, so no separate counter.
    assign act_addr = weight_addr[9:0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            n           <= '0;
            vld         <= 1'b0;
            acc         <= '0;
            weight_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            done <= 1'b0;
            vld  <= state == FETCH;
            if (vld) acc <= acc + ACC_W'(prod);
            case (state)
                IDLE: if (start) begin
                    n    <= n_clamp;
                    acc  <= '0;
                    busy <= 1'b1;
                    if (n_clamp == 11'd0) state <= DRAIN;
                    else begin
                        weight_addr <= {layer, neuron, 10'd0};
                        state       <= FETCH;
                    end
                end
                FETCH: if ({1'b0, weight_addr[9:0]} == n - 11'd1) state <= DRAIN;
                       else weight_addr[9:0] <= weight_addr[9:0] + 10'd1;
                DRAIN: state <= OUT;
                OUT: begin
                    result <= sat;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: drives two neuron_mac_seq instances (RELU on/off) from a
// shared registered memory model and checks them against a sum-of-products model.
module tb_neuron_mac_seq;
    logic        clk = 0;
    logic        reset = 0;
    logic        start = 0;
    logic [1:0]  layer = 0;
    logic [3:0]  neuron = 0;
    logic [10:0] num_inputs = 0;
    logic [7:0]  weight_val, act_val;
    logic [15:0] wa1, wa0;
    logic [9:0]  aa1, aa0;
    logic        busy1, busy0, done1, done0;
    logic [7:0]  res1, res0;
    logic signed [7:0] w_mem [0:65535];
    logic signed [7:0] a_mem [0:1023];
    int checks = 0;
    int failures = 0;
    int exp_last = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.ACC_W(26), .SHIFT(4), .RELU(1)) u_relu (
        .clk(clk), .reset(reset), .start(start), .layer(layer), .neuron(neuron),
        .num_inputs(num_inputs), .weight_addr(wa1), .weight_val(weight_val),
        .act_addr(aa1), .act_val(act_val), .busy(busy1), .done(done1), .result(res1));

    neuron_mac_seq #(.ACC_W(26), .SHIFT(4), .RELU(0)) u_lin (
        .clk(clk), .reset(reset), .start(start), .layer(layer), .neuron(neuron),
        .num_inputs(num_inputs), .weight_addr(wa0), .weight_val(weight_val),
        .act_addr(aa0), .act_val(act_val), .busy(busy0), .done(done0), .result(res0));

    // One-cycle registered read, as the upstream memories provide.
    always @(posedge clk) begin
        weight_val <= w_mem[wa1];
        act_val    <= a_mem[aa1];
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_res(input int acc, input bit relu);
        int s;
        s = acc >>> 4;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int addr_of(input int l, input int nr, input int k);
        return (l << 14) | (nr << 10) | k;
    endfunction

    task automatic fill(input int l, input int nr, input int n, input int w, input int a);
        for (int k = 0; k < n; k++) begin
            w_mem[addr_of(l, nr, k)] = 8'(w);
            a_mem[k] = 8'(a);
        end
    endtask

    task automatic fill_rand(input int l, input int nr, input int n);
        for (int k = 0; k < n; k++) begin
            w_mem[addr_of(l, nr, k)] = 8'($urandom);
            a_mem[k] = 8'($urandom);
        end
    endtask

    task automatic run(input int l, input int nr, input int n, input bit spur);
        int ne, acc, last, ea;
        ne = n > 1024 ? 1024 : n;
        acc = 0;
        for (int k = 0; k < ne; k++)
            acc += int'(w_mem[addr_of(l, nr, k)]) * int'(a_mem[k]);
        last = ne > 0 ? addr_of(l, nr, ne - 1) : exp_last;
        @(negedge clk);
        start = 1; layer = 2'(l); neuron = 4'(nr); num_inputs = 11'(n);
        for (int c = 0; c <= ne + 3; c++) begin
            @(negedge clk);
            start = spur && c == 2;
            layer = (spur && c == 2) ? ~2'(l) : 2'(l);
            num_inputs = (spur && c == 2) ? 11'd5 : 11'(n);
            ea = c < ne ? addr_of(l, nr, c) : last;
            check("busy", int'(busy1), int'(c < ne + 2));
            check("busy_lin", int'(busy0), int'(c < ne + 2));
            check("done", int'(done1), int'(c == ne + 2));
            check("done_lin", int'(done0), int'(c == ne + 2));
            check("waddr", int'(wa1), ea);
            check("waddr_lin", int'(wa0), ea);
            check("aaddr", int'(aa1), ea & 1023);
            if (c == ne + 2) begin
                check("result_relu", int'($signed(res1)), ref_res(acc, 1'b1));
                check("result_lin", int'($signed(res0)), ref_res(acc, 1'b0));
            end
        end
        exp_last = last;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) w_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) a_mem[i] = 8'($urandom);
        #12;
        check("rst_waddr", int'(wa1), 0);
        check("rst_aaddr", int'(aa1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_result", int'(res1), 0);
        @(negedge clk);
        reset = 1;
        fill(0, 0, 16, 2, 3);      run(0, 0, 16, 0);
        fill(1, 2, 4, 2, 10);      run(1, 2, 4, 0);
        fill(0, 5, 16, 2, -50);    run(0, 5, 16, 0);
        fill(3, 1, 16, 127, 127);  run(3, 1, 16, 0);
        run(2, 7, 0, 0);
        fill(1, 1, 16, -3, 7);     run(1, 1, 16, 1);
        // Asynchronous reset in the middle of an N=16 evaluation.
        fill(2, 3, 16, 5, 5);
        @(negedge clk);
        start = 1; layer = 2; neuron = 3; num_inputs = 16;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = 0;
        end
        reset = 0;
        #1;
        check("mid_rst_waddr", int'(wa1), 0);
        check("mid_rst_aaddr", int'(aa0), 0);
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_result", int'(res0), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_done", int'(done1 | done0), 0);
        end
        reset = 1;
        exp_last = 0;
        run(2, 3, 16, 0);
        fill_rand(0, 9, 1024);     run(0, 9, 1030, 0);
        for (int t = 0; t < 14; t++) begin
            int l, nr, n, r;
            l = $urandom_range(0, 3);
            nr = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            n = r == 0 ? 0 : r == 1 ? 1 : $urandom_range(2, 48);
            fill_rand(l, nr, n);
            run(l, nr, n, r == 2);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
